intersection_phase_scheduler: RTL and testbench

- Sequences right-of-way at a four-approach intersection.
- Grants green to one approach at a time, round-robin, among approaches whose vehicle sensor is asserted. Each green runs within min/max limits, then passes through yellow and all-red clearance.
- Serves a latched pedestrian request with an exclusive all-red WALK phase.
- Sits above the per-road light decoders and drives all four light pairs plus the walk signal.

---
 rtl/intersection_phase_scheduler.sv | 133 +++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_scheduler.sv
// Four-approach intersection right-of-way scheduler.
// Round-robin green among demanding approaches, yellow and all-red clearance,
// and an exclusive all-red pedestrian WALK phase for latched button presses.
module intersection_phase_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3,
  parameter int CNT_W     = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sensor,
  input  logic       ped_req,
  output logic [7:0] light,
  output logic       walk,
  output logic [1:0] grant,
  output logic       ped_pending
);

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2,
    S_WALK    = 2'd3
  } state_t;

  // Lamp encodings per approach.
  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;

  // Terminal counts; "reached" thresholds are compared as count+1 >= T so a
  // duration of 1 never turns into a compare against zero.
  localparam logic [CNT_W-1:0] GREEN_MAX_L = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_L    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] WALK_L      = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W:0]   GREEN_MIN_W = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0]   ALLRED_W    = (CNT_W+1)'(ALLRED_T);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       grant_q, grant_d;
  logic             ped_pending_q, ped_pending_d;
  logic             ped_last_q, ped_last_d;
  logic [CNT_W:0]   count_plus1;
  logic [3:0]       other_demand;

  // First asserted request searching upward (mod 4) from last+1; lowest
  // offset wins because it is written last.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + i[1:0];
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  // Next-state, grant and pedestrian bookkeeping.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ped_last_d    = ped_last_q;
    ped_pending_d = ped_pending_q | ped_req;
    count_plus1   = {1'b0, count_q} + 1'b1;
    other_demand  = sensor & ~(4'b0001 << grant_q);
    case (state_q)
      S_ALL_RED: begin
        if (count_plus1 >= ALLRED_W) begin
          if (ped_pending_q && (!ped_last_q || sensor == 4'd0)) begin
            state_d       = S_WALK;
            ped_last_d    = 1'b1;
            ped_pending_d = 1'b0;  // a press on this edge is served by this WALK
          end else if (sensor != 4'd0) begin
            state_d    = S_GREEN;
            grant_d    = rr_pick(grant_q, sensor);
            ped_last_d = 1'b0;
          end
        end
      end
      S_GREEN: begin
        if (count_q == GREEN_MAX_L ||
            (count_plus1 >= GREEN_MIN_W &&
             (!sensor[grant_q] || other_demand != 4'd0 || ped_pending_q)))
          state_d = S_YELLOW;
      end
      S_YELLOW: begin
        if (count_q == YELLOW_L) state_d = S_ALL_RED;
      end
      S_WALK: begin
        if (count_q == WALK_L) state_d = S_ALL_RED;
      end
      default: state_d = S_ALL_RED;
    endcase
    if (state_d != state_q)  count_d = '0;
    else if (count_q != '1)  count_d = count_q + 1'b1;
    else                     count_d = count_q;
  end

  // State, counter, grant pointer and pedestrian latch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_ALL_RED;
      count_q       <= '0;
      grant_q       <= 2'd3;
      ped_pending_q <= 1'b0;
      ped_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      grant_q       <= grant_d;
      ped_pending_q <= ped_pending_d;
      ped_last_q    <= ped_last_d;
    end
  end

  // Lamp decode from registered state and grant only.
  always_comb begin
    light = 8'b10101010;
    walk  = 1'b0;
    case (state_q)
      S_GREEN:  light[2*grant_q +: 2] = LAMP_GREEN;
      S_YELLOW: light[2*grant_q +: 2] = LAMP_YELLOW;
      S_WALK:   walk = 1'b1;
      default:  ;
    endcase
  end

  assign grant       = grant_q;
  assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with per-scenario tasks.
module tb_intersection_phase_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] sensor;
  logic       ped_req;
  logic [7:0] light;
  logic       walk;
  logic [1:0] grant;
  logic       ped_pending;

  int tests_run;
  int tests_failed;

  intersection_phase_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .sensor      (sensor),
    .ped_req     (ped_req),
    .light       (light),
    .walk        (walk),
    .grant       (grant),
    .ped_pending (ped_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 all-red, 1 green, 2 yellow, 3 walk
  function automatic logic [7:0] exp_light(input int kind, input logic [1:0] g);
    logic [7:0] l;
    l = 8'b10101010;
    if (kind == 1) l[2*g +: 2] = 2'b00;
    if (kind == 2) l[2*g +: 2] = 2'b01;
    return l;
  endfunction

  task automatic do_reset(input logic [3:0] s, input logic p);
    @(negedge clk);
    rst = 1'b0; sensor = 4'd0; ped_req = 1'b0;
    @(negedge clk);
    rst = 1'b1; sensor = s; ped_req = p;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; sensor = 4'd0; ped_req = 1'b0;
    #12;
    tests_run++;
    if (light !== 8'b10101010 || walk !== 1'b0 || grant !== 2'd3 || ped_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset light=%b walk=%b grant=%0d ped=%b required light=10101010 walk=0 grant=3 ped=0",
               light, walk, grant, ped_pending);
    end
  endtask

  task automatic test_max_out();
    int kind;
    do_reset(4'b0100, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      step();
      kind = (k <= 10) ? 1 : (k <= 12) ? 2 : (k == 13) ? 0 : 1;
      tests_run++;
      if (light !== exp_light(kind, 2'd2) || grant !== 2'd2 || walk !== 1'b0) begin
        tests_failed++;
        $display("FAIL max_out k=%0d light=%b grant=%0d walk=%b required light=%b grant=2 walk=0",
                 k, light, grant, walk, exp_light(kind, 2'd2));
      end
    end
  endtask

  task automatic test_gap_out();
    int kind;
    do_reset(4'b0001, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step();
      kind = (k <= 4) ? 1 : (k <= 6) ? 2 : 0;
      tests_run++;
      if (light !== exp_light(kind, 2'd0) || grant !== 2'd0 || walk !== 1'b0) begin
        tests_failed++;
        $display("FAIL gap_out k=%0d light=%b grant=%0d walk=%b required light=%b grant=0 walk=0",
                 k, light, grant, walk, exp_light(kind, 2'd0));
      end
      if (k == 2) sensor = 4'd0;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [4];
    logic [1:0] g;
    int p, kind;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd3; seq[3] = 2'd0;
    do_reset(4'b1011, 1'b0);
    for (int k = 1; k <= 28; k++) begin
      step();
      p    = (k - 1) % 7;
      g    = seq[(k - 1) / 7];
      kind = (p <= 3) ? 1 : (p <= 5) ? 2 : 0;
      tests_run++;
      if (light !== exp_light(kind, g) || grant !== g) begin
        tests_failed++;
        $display("FAIL round_robin k=%0d light=%b grant=%0d required light=%b grant=%0d",
                 k, light, grant, exp_light(kind, g), g);
      end
    end
  endtask

  task automatic test_pedestrian();
    int kind;
    logic ep;
    do_reset(4'b0010, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      kind = (k <= 4) ? 1 : (k <= 6) ? 2 : (k == 7) ? 0 : (k <= 10) ? 3 : (k == 11) ? 0 : 1;
      ep   = (k >= 3 && k <= 7);
      tests_run++;
      if (light !== exp_light(kind, 2'd1) || grant !== 2'd1 ||
          walk !== (kind == 3) || ped_pending !== ep) begin
        tests_failed++;
        $display("FAIL pedestrian k=%0d light=%b grant=%0d walk=%b ped=%b required light=%b grant=1 walk=%b ped=%b",
                 k, light, grant, walk, ped_pending, exp_light(kind, 2'd1), (kind == 3), ep);
      end
      if (k == 2) ped_req = 1'b1;
      if (k == 3) ped_req = 1'b0;
    end
  endtask

  task automatic test_ped_fairness();
    int p, kind;
    logic ep;
    do_reset(4'b0010, 1'b1);
    for (int k = 1; k <= 22; k++) begin
      step();
      p    = (k - 1) % 11;
      kind = (p <= 3) ? 1 : (p <= 5) ? 2 : (p == 6) ? 0 : (p <= 9) ? 3 : 0;
      ep   = (p != 7);
      tests_run++;
      if (light !== exp_light(kind, 2'd1) || walk !== (kind == 3) || ped_pending !== ep) begin
        tests_failed++;
        $display("FAIL ped_fairness k=%0d light=%b walk=%b ped=%b required light=%b walk=%b ped=%b",
                 k, light, walk, ped_pending, exp_light(kind, 2'd1), (kind == 3), ep);
      end
    end
    ped_req = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset(4'b0100, 1'b1);
    step();
    ped_req = 1'b0;
    sensor  = 4'd0;
    for (int k = 2; k <= 5; k++) step();
    tests_run++;
    if (light !== 8'b10011010 || ped_pending !== 1'b1 || grant !== 2'd2) begin
      tests_failed++;
      $display("FAIL pre_async_yellow light=%b ped=%b grant=%0d required light=10011010 ped=1 grant=2",
               light, ped_pending, grant);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (light !== 8'b10101010 || walk !== 1'b0 || grant !== 2'd3 || ped_pending !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset light=%b walk=%b grant=%0d ped=%b required light=10101010 walk=0 grant=3 ped=0",
               light, walk, grant, ped_pending);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b0; sensor = 4'd0; ped_req = 1'b0;
    test_reset();
    test_max_out();
    test_gap_out();
    test_round_robin();
    test_pedestrian();
    test_ped_fairness();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
